// File: rtl/alarm_ctrl.sv
// Alarm sequencer driving ALARM_ENABLE/ALARM_DOING for the piezo; all outputs registered, 1-cycle latency.
// Define ALARM_PULSE_EN for a 1 s on / 1 s off ALARM_DOING cadence while ringing (default: steady on).
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       TICK_1S,
  input  logic [4:0] CUR_HOUR,
  input  logic [5:0] CUR_MIN,
  input  logic [5:0] CUR_SEC,
  input  logic [4:0] SET_HOUR,
  input  logic [5:0] SET_MIN,
  input  logic       ALM_SET,
  input  logic       ALM_ON,
  input  logic       KEY_STOP,
  input  logic       KEY_SNOOZE,
  output logic       ALARM_ENABLE,
  output logic       ALARM_DOING,
  output logic [1:0] STATE,
  output logic [3:0] SNOOZE_NUM,
  output logic [4:0] ALM_HOUR,
  output logic [5:0] ALM_MIN
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2,
    S_SNOOZE  = 2'd3
  } state_t;

  localparam logic [15:0] RING_LAST   = 16'(RING_SEC - 1);
  localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SEC - 1);
  localparam logic [3:0]  SNOOZE_MAX  = 4'(MAX_SNOOZE);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  snooze_num_q, snooze_num_d;
  logic [4:0]  alm_hour_q, alm_hour_d;
  logic [5:0]  alm_min_q, alm_min_d;
  logic        enable_q, enable_d;
  logic        doing_q, doing_d;
  logic        alarm_match;
  logic        ring_tick;

  assign alarm_match = TICK_1S && (CUR_HOUR == alm_hour_q) && (CUR_MIN == alm_min_q) &&
                       (CUR_SEC == 6'd0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    snooze_num_d = snooze_num_q;
    alm_hour_d   = alm_hour_q;
    alm_min_d    = alm_min_q;
    ring_tick    = 1'b0;

    if (ALM_SET) begin
      alm_hour_d = SET_HOUR;
      alm_min_d  = SET_MIN;
    end

    if (!ALM_ON) begin
      state_d      = S_IDLE;
      cnt_d        = 16'd0;
      snooze_num_d = 4'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d      = S_ARMED;
          snooze_num_d = 4'd0;
        end
        S_ARMED: begin
          // A key press in the match cycle swallows the tick, so no ring starts.
          if (!KEY_STOP && !KEY_SNOOZE && alarm_match) begin
            state_d = S_RINGING;
            cnt_d   = 16'd0;
          end
        end
        S_RINGING: begin
          if (KEY_STOP) begin
            state_d      = S_ARMED;
            snooze_num_d = 4'd0;
          end else if (KEY_SNOOZE) begin
            if (snooze_num_q < SNOOZE_MAX) begin
              state_d      = S_SNOOZE;
              snooze_num_d = snooze_num_q + 4'd1;
              cnt_d        = 16'd0;
            end else begin
              state_d      = S_ARMED;
              snooze_num_d = 4'd0;
            end
          end else if (TICK_1S) begin
            if (cnt_q == RING_LAST) begin
              state_d      = S_ARMED;
              snooze_num_d = 4'd0;
            end else begin
              cnt_d     = cnt_q + 16'd1;
              ring_tick = 1'b1;
            end
          end
        end
        S_SNOOZE: begin
          if (KEY_STOP) begin
            state_d      = S_ARMED;
            snooze_num_d = 4'd0;
          end else if (TICK_1S) begin
            if (cnt_q == SNOOZE_LAST) begin
              state_d = S_RINGING;
              cnt_d   = 16'd0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    enable_d = (state_d != S_IDLE);
`ifdef ALARM_PULSE_EN
    if (state_d != S_RINGING) begin
      doing_d = 1'b0;
    end else if (state_q != S_RINGING) begin
      doing_d = 1'b1;
    end else if (ring_tick) begin
      doing_d = ~doing_q;
    end else begin
      doing_d = doing_q;
    end
`else
    doing_d = (state_d == S_RINGING);
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      snooze_num_q <= 4'd0;
      alm_hour_q   <= 5'd0;
      alm_min_q    <= 6'd0;
      enable_q     <= 1'b0;
      doing_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      snooze_num_q <= snooze_num_d;
      alm_hour_q   <= alm_hour_d;
      alm_min_q    <= alm_min_d;
      enable_q     <= enable_d;
      doing_q      <= doing_d;
    end
  end

  assign ALARM_ENABLE = enable_q;
  assign ALARM_DOING  = doing_q;
  assign STATE        = state_q;
  assign SNOOZE_NUM   = snooze_num_q;
  assign ALM_HOUR     = alm_hour_q;
  assign ALM_MIN      = alm_min_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with RING_SEC=5, SNOOZE_SEC=3, MAX_SNOOZE=2.
module tb_alarm_ctrl;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       TICK_1S;
  logic [4:0] CUR_HOUR;
  logic [5:0] CUR_MIN;
  logic [5:0] CUR_SEC;
  logic [4:0] SET_HOUR;
  logic [5:0] SET_MIN;
  logic       ALM_SET;
  logic       ALM_ON;
  logic       KEY_STOP;
  logic       KEY_SNOOZE;
  logic       ALARM_ENABLE;
  logic       ALARM_DOING;
  logic [1:0] STATE;
  logic [3:0] SNOOZE_NUM;
  logic [4:0] ALM_HOUR;
  logic [5:0] ALM_MIN;

  int checks = 0;
  int failures = 0;

  alarm_ctrl #(.RING_SEC(5), .SNOOZE_SEC(3), .MAX_SNOOZE(2)) dut (
    .CLK(CLK), .RESETN(RESETN), .TICK_1S(TICK_1S),
    .CUR_HOUR(CUR_HOUR), .CUR_MIN(CUR_MIN), .CUR_SEC(CUR_SEC),
    .SET_HOUR(SET_HOUR), .SET_MIN(SET_MIN), .ALM_SET(ALM_SET), .ALM_ON(ALM_ON),
    .KEY_STOP(KEY_STOP), .KEY_SNOOZE(KEY_SNOOZE),
    .ALARM_ENABLE(ALARM_ENABLE), .ALARM_DOING(ALARM_DOING), .STATE(STATE),
    .SNOOZE_NUM(SNOOZE_NUM), .ALM_HOUR(ALM_HOUR), .ALM_MIN(ALM_MIN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; sample 1 time unit later, then drop the single-cycle pulses.
  task automatic cyc();
    @(posedge CLK);
    #1;
    TICK_1S    = 1'b0;
    ALM_SET    = 1'b0;
    KEY_STOP   = 1'b0;
    KEY_SNOOZE = 1'b0;
  endtask

  task automatic tick(input logic [5:0] sec);
    CUR_SEC = sec;
    TICK_1S = 1'b1;
    cyc();
  endtask

  logic exp_doing;

  initial begin
    RESETN = 1'b0; TICK_1S = 1'b0; ALM_SET = 1'b0; ALM_ON = 1'b0;
    KEY_STOP = 1'b0; KEY_SNOOZE = 1'b0;
    CUR_HOUR = 5'd7; CUR_MIN = 6'd30; CUR_SEC = 6'd0;
    SET_HOUR = 5'd0; SET_MIN = 6'd0;
    cyc(); cyc();
    chk("rst_state", 8'(STATE), 8'd0);
    chk("rst_enable", 8'(ALARM_ENABLE), 8'd0);
    chk("rst_doing", 8'(ALARM_DOING), 8'd0);
    chk("rst_snooze_num", 8'(SNOOZE_NUM), 8'd0);
    chk("rst_hour", 8'(ALM_HOUR), 8'd0);
    chk("rst_min", 8'(ALM_MIN), 8'd0);

    // Arm and load 07:30.
    RESETN = 1'b1; ALM_ON = 1'b1; ALM_SET = 1'b1; SET_HOUR = 5'd7; SET_MIN = 6'd30;
    cyc();
    chk("arm_state", 8'(STATE), 8'd1);
    chk("arm_enable", 8'(ALARM_ENABLE), 8'd1);
    chk("arm_doing", 8'(ALARM_DOING), 8'd0);
    chk("arm_hour", 8'(ALM_HOUR), 8'd7);
    chk("arm_min", 8'(ALM_MIN), 8'd30);

    CUR_MIN = 6'd29; tick(6'd59);
    chk("no_match_state", 8'(STATE), 8'd1);
    CUR_MIN = 6'd30; tick(6'd0);
    chk("ring_state", 8'(STATE), 8'd2);
    chk("ring_doing", 8'(ALARM_DOING), 8'd1);
    chk("ring_enable", 8'(ALARM_ENABLE), 8'd1);

    // Timeout after 5 ticks; with the pulse cadence DOING toggles per tick.
    for (int i = 1; i <= 4; i++) begin
      tick(6'(i));
      chk("timeout_ringing", 8'(STATE), 8'd2);
`ifdef ALARM_PULSE_EN
      exp_doing = (i % 2 == 0);
`else
      exp_doing = 1'b1;
`endif
      chk("ring_doing_seq", 8'(ALARM_DOING), 8'(exp_doing));
    end
    tick(6'd5);
    chk("timeout_state", 8'(STATE), 8'd1);
    chk("timeout_doing", 8'(ALARM_DOING), 8'd0);
    for (int s = 6; s <= 59; s++) begin
      tick(6'(s));
      chk("no_reringing", 8'(STATE), 8'd1);
    end

    // Snooze twice, third snooze acts as stop.
    tick(6'd0);
    chk("ring2_state", 8'(STATE), 8'd2);
    KEY_SNOOZE = 1'b1; cyc();
    chk("snz1_state", 8'(STATE), 8'd3);
    chk("snz1_num", 8'(SNOOZE_NUM), 8'd1);
    chk("snz1_doing", 8'(ALARM_DOING), 8'd0);
    chk("snz1_enable", 8'(ALARM_ENABLE), 8'd1);
    tick(6'd1); tick(6'd2);
    chk("snz1_hold", 8'(STATE), 8'd3);
    tick(6'd3);
    chk("snz1_end_state", 8'(STATE), 8'd2);
    chk("snz1_end_doing", 8'(ALARM_DOING), 8'd1);
    KEY_SNOOZE = 1'b1; cyc();
    chk("snz2_state", 8'(STATE), 8'd3);
    chk("snz2_num", 8'(SNOOZE_NUM), 8'd2);
    tick(6'd4); tick(6'd5); tick(6'd6);
    chk("snz2_end_state", 8'(STATE), 8'd2);
    KEY_SNOOZE = 1'b1; cyc();
    chk("snz_limit_state", 8'(STATE), 8'd1);
    chk("snz_limit_num", 8'(SNOOZE_NUM), 8'd0);

    // Stop, snooze and tick together: stop wins.
    tick(6'd0);
    KEY_SNOOZE = 1'b1; cyc();
    chk("pre_stop_num", 8'(SNOOZE_NUM), 8'd1);
    tick(6'd1); tick(6'd2); tick(6'd3);
    chk("pre_stop_state", 8'(STATE), 8'd2);
    KEY_STOP = 1'b1; KEY_SNOOZE = 1'b1; tick(6'd4);
    chk("stop_state", 8'(STATE), 8'd1);
    chk("stop_num", 8'(SNOOZE_NUM), 8'd0);
    chk("stop_doing", 8'(ALARM_DOING), 8'd0);

    // Disarm during snooze.
    tick(6'd0);
    KEY_SNOOZE = 1'b1; cyc();
    chk("pre_off_state", 8'(STATE), 8'd3);
    ALM_ON = 1'b0; cyc();
    chk("off_state", 8'(STATE), 8'd0);
    chk("off_enable", 8'(ALARM_ENABLE), 8'd0);
    chk("off_num", 8'(SNOOZE_NUM), 8'd0);
    ALM_ON = 1'b1; cyc();
    chk("rearm_state", 8'(STATE), 8'd1);

    // Reload during ringing keeps the current event; then reset mid-ring.
    tick(6'd0);
    chk("ring3_state", 8'(STATE), 8'd2);
    ALM_SET = 1'b1; SET_HOUR = 5'd8; SET_MIN = 6'd15; cyc();
    chk("reload_state", 8'(STATE), 8'd2);
    chk("reload_hour", 8'(ALM_HOUR), 8'd8);
    chk("reload_min", 8'(ALM_MIN), 8'd15);
    tick(6'd1);
    chk("reload_keep_ring", 8'(STATE), 8'd2);
    RESETN = 1'b0; cyc();
    chk("mid_rst_state", 8'(STATE), 8'd0);
    chk("mid_rst_doing", 8'(ALARM_DOING), 8'd0);
    chk("mid_rst_enable", 8'(ALARM_ENABLE), 8'd0);
    chk("mid_rst_num", 8'(SNOOZE_NUM), 8'd0);
    chk("mid_rst_hour", 8'(ALM_HOUR), 8'd0);
    chk("mid_rst_min", 8'(ALM_MIN), 8'd0);
    RESETN = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm sequencer that generates ALARM_ENABLE / ALARM_DOING for the piezo tone unit, i.e. the initiator side of that interface.
- Compares the running clock time against a stored alarm time, starts ringing on match, and handles stop, snooze, ring timeout and the snooze limit.
- Sits between the timekeeping / key-debounce logic and the piezo driver.

Parameters:
- RING_SEC, 60, number of TICK_1S pulses one ring period lasts before auto-timeout
- SNOOZE_SEC, 300, number of TICK_1S pulses one snooze period lasts
- MAX_SNOOZE, 3, snoozes allowed per alarm event; a snooze request beyond this acts as stop

Ports:
- CLK  in  1  system clock
- RESETN  in  1  reset
- TICK_1S  in  1  one-CLK pulse per second from timekeeper
- CUR_HOUR  in  5  current hour 0-23
- CUR_MIN  in  6  current minute 0-59
- CUR_SEC  in  6  current second 0-59
- SET_HOUR  in  5  alarm hour to load
- SET_MIN  in  6  alarm minute to load
- ALM_SET  in  1  one-CLK pulse; latch SET_HOUR/SET_MIN
- ALM_ON  in  1  level; alarm armed switch
- KEY_STOP  in  1  one-CLK debounced pulse
- KEY_SNOOZE  in  1  one-CLK debounced pulse
- ALARM_ENABLE  out  1  to piezo; tone counter run enable
- ALARM_DOING  out  1  to piezo; tone output gate
- STATE  out  2  0=IDLE 1=ARMED 2=RINGING 3=SNOOZE
- SNOOZE_NUM  out  4  snoozes used in the current event
- ALM_HOUR  out  5  stored alarm hour (for display)
- ALM_MIN  out  6  stored alarm minute (for display)

Behaviour:
- Reset is RESETN, synchronous, active-low; clock is CLK (rising edge).
- On reset: STATE=IDLE, ALARM_ENABLE=0, ALARM_DOING=0, SNOOZE_NUM=0, ALM_HOUR=0, ALM_MIN=0, second counter=0.
- All outputs are registered and change on the CLK edge after the qualifying input cycle (1-cycle latency).
- Alarm time registers:
  - ALM_SET=1 loads SET_HOUR/SET_MIN in any state.
  - A load during RINGING or SNOOZE does not affect the current event.
- Outputs by state:
  - ALARM_ENABLE=1 in ARMED, RINGING and SNOOZE; 0 in IDLE.
  - ALARM_DOING=1 only in RINGING.
- Transition priority, highest first:
  1. ALM_ON=0: go to IDLE from any state; SNOOZE_NUM and counter clear.
  2. KEY_STOP.
  3. KEY_SNOOZE.
  4. TICK_1S events.
- IDLE -> ARMED when ALM_ON=1.
- ARMED -> RINGING on a cycle with TICK_1S=1, CUR_HOUR==ALM_HOUR, CUR_MIN==ALM_MIN and CUR_SEC==0; counter clears.
  - Entering ARMED from any state clears SNOOZE_NUM.
- RINGING:
  - KEY_STOP -> ARMED.
  - KEY_SNOOZE with SNOOZE_NUM<MAX_SNOOZE -> SNOOZE, SNOOZE_NUM+1, counter=0.
  - KEY_SNOOZE with SNOOZE_NUM==MAX_SNOOZE -> ARMED (treated as stop).
  - TICK_1S: if counter==RING_SEC-1 -> ARMED (timeout), else counter+1.
- SNOOZE:
  - KEY_STOP -> ARMED.
  - KEY_SNOOZE is ignored.
  - TICK_1S: if counter==SNOOZE_SEC-1 -> RINGING with counter=0, else counter+1.
- KEY_STOP and KEY_SNOOZE in the same cycle: stop wins.
- A key and TICK_1S in the same cycle: the key wins and the tick is discarded.
- Counter is 16 bits, unsigned, and never wraps (bounded by the compares). SNOOZE_NUM saturates at MAX_SNOOZE.
- Re-trigger: after a stop or timeout in the same minute, no re-ring, because the match requires CUR_SEC==0.
- Reset asserted mid-RINGING: ALARM_DOING=0 at the next edge.

Optional Feature:
- Macro ALARM_PULSE_EN.
- Defined: in RINGING, ALARM_DOING is a 1 s on / 1 s off cadence.
  - ALARM_DOING=1 on entry to RINGING.
  - ALARM_DOING toggles on each TICK_1S while in RINGING.
  - It is forced to 0 on leaving RINGING.
- Not defined: ALARM_DOING is held at 1 for the whole of RINGING.

Test Plan (bench params RING_SEC=5, SNOOZE_SEC=3, MAX_SNOOZE=2):
- Reset, ALM_ON=1, ALM_SET with 07:30; drive 07:30:00 with TICK_1S -> STATE 1->2 one cycle later, ALARM_DOING=1, ALARM_ENABLE=1.
- Ringing, no keys, 5 TICK_1S pulses -> STATE=1 after the 5th tick, ALARM_DOING=0; further ticks at 07:30:01..59 -> no re-ring.
- Ring, KEY_SNOOZE -> STATE=3, SNOOZE_NUM=1; 3 ticks -> STATE=2; KEY_SNOOZE -> SNOOZE_NUM=2; 3 ticks -> STATE=2; KEY_SNOOZE -> STATE=1, SNOOZE_NUM=0.
- Ringing, KEY_STOP and KEY_SNOOZE in the same cycle with TICK_1S -> STATE=1, SNOOZE_NUM=0.
- ALM_ON driven to 0 during SNOOZE -> STATE=0, ALARM_ENABLE=0 next cycle; RESETN=0 during RINGING -> all outputs at reset values next edge.
- With ALARM_PULSE_EN defined: ring, 4 ticks -> ALARM_DOING sequence 1,0,1,0,1 sampled after each tick.
